mpy_seq: RTL and testbench
==========================

MPY_SEQ -- requirements
Module: mpy_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port sgn, input, 1 bit: 1 = two's-complement signed operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have ports S and T, input, WIDTH bits each: the multiplicand and multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have ports Y_hi and Y_lo, output, WIDTH bits each: the upper and lower halves of the 2*WIDTH-bit product, registered.
REQ-010 The block SHALL have ports C, V, N, Z, output, 1 bit each: status flags, registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 IDLE -> CALC SHALL occur on a clock edge where start=1; S, T and sgn are latched, an internal accumulator is cleared and the bit counter is loaded with WIDTH.
REQ-013 While in IDLE with start=0, the block SHALL stay in IDLE and hold all outputs.
REQ-014 CALC SHALL run radix-2 shift-add on operand magnitudes, one multiplier bit per cycle, decrementing the counter.
REQ-015 CALC -> DONE SHALL occur when the counter reaches 0; nominal latency is WIDTH cycles in CALC.
REQ-016 In DONE, the block SHALL update Y_hi, Y_lo and the flags, assert done for exactly that one cycle, and then move unconditionally to IDLE.
REQ-017 start SHALL be ignored in CALC and DONE, with no queuing; a start in the cycle after DONE, i.e. in IDLE, SHALL be accepted.
REQ-018 In unsigned mode, {Y_hi,Y_lo} SHALL equal S*T exactly as a 2*WIDTH-bit unsigned value.
REQ-019 In signed mode, the magnitude of each operand SHALL be taken, and the product negated when S[WIDTH-1] XOR T[WIDTH-1] = 1.
REQ-020 In signed mode, {Y_hi,Y_lo} SHALL be the exact 2*WIDTH-bit two's-complement product, including the most-negative x most-negative case.
REQ-021 The flags SHALL be: C=0 and V=0 always (the full product cannot overflow); N=Y_hi[WIDTH-1]; Z=1 iff all 2*WIDTH product bits are 0.
REQ-022 Y_hi, Y_lo and the flags SHALL change only in DONE, or on reset, and SHALL hold between operations.
REQ-023 Operand changes on S, T or sgn after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-024 When reset=1, regardless of clk, the block SHALL force the state to IDLE and set busy=0, done=0, Y_hi=0, Y_lo=0, C=0, V=0, N=0 and Z=1.
REQ-025 A reset asserted mid-CALC SHALL abort the operation with no done pulse; after reset is released, the next start begins a clean operation.
REQ-026 The internal accumulator, operand registers and counter SHALL also be cleared by reset.

Configuration
REQ-027 The macro MPY_SEQ_EARLY_TERM_EN SHALL control early termination.
REQ-028 With MPY_SEQ_EARLY_TERM_EN defined, CALC SHALL go to DONE as soon as the remaining unshifted multiplier magnitude is 0, so the CALC cycle count is the bit position of the highest 1 plus one, minimum 1 cycle (multiplier = 0 takes 1 cycle).
REQ-029 With MPY_SEQ_EARLY_TERM_EN undefined, CALC SHALL always take exactly WIDTH cycles.
REQ-030 Results SHALL be identical with and without MPY_SEQ_EARLY_TERM_EN; only latency differs.

Verification
REQ-031 The bench SHALL cover this case: WIDTH=32, sgn=0, S=0xFFFFFFFF, T=0xFFFFFFFF -> Y_hi=0xFFFFFFFE, Y_lo=0x00000001, N=1, Z=0, done exactly 33 cycles after the start edge (macro off).
REQ-032 The bench SHALL cover this case: sgn=1, S=0xFFFFFFFD (-3), T=0x00000007 -> Y_hi=0xFFFFFFFF, Y_lo=0xFFFFFFEB, N=1, Z=0, C=0, V=0.
REQ-033 The bench SHALL cover this case: sgn=1, S=T=0x80000000 -> Y_hi=0x40000000, Y_lo=0x00000000, N=0, Z=0.
REQ-034 The bench SHALL cover this case: S=0x12345678, T=0 -> Y_hi=Y_lo=0, Z=1; with the macro on, done arrives 2 cycles after start, and with it off, 33 cycles after start.
REQ-035 The bench SHALL cover this case: start pulsed again while busy, with new S and T -> the first result is unchanged and exactly one done pulse occurs.
REQ-036 The bench SHALL cover this case: reset asserted at CALC cycle 10 -> busy=0 immediately, no done, outputs at reset values; a following start with S=6, T=7 -> Y_lo=42.

Source files
------------

// File: rtl/mpy_seq.sv
// mpy_seq: sequential radix-2 shift-add multiplier, signed or unsigned operands.
// The operands' magnitudes are multiplied one multiplier bit per CALC cycle, and
// the product is negated at the end when the operand signs differ.
// Optional feature macro: MPY_SEQ_EARLY_TERM_EN. When it is defined, CALC ends
// as soon as the remaining multiplier magnitude is zero. When it is undefined,
// CALC always runs WIDTH cycles.
module mpy_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Datapath: the magnitude accumulator, the shifted multiplicand, and the
  // multiplier that remains to be processed.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mult;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;

  // Registered results.
  logic               r_done;
  logic [WIDTH-1:0]   r_y_hi;
  logic [WIDTH-1:0]   r_y_lo;
  logic               r_c;
  logic               r_v;
  logic               r_n;
  logic               r_z;

  logic [WIDTH-1:0]   w_s_mag;
  logic [WIDTH-1:0]   w_t_mag;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_last;

  // Take magnitudes in WIDTH bits. The most-negative value maps to 2^(WIDTH-1),
  // which is still exact when the result is read as unsigned.
  assign w_s_mag    = (sgn && S[WIDTH-1]) ? -S : S;
  assign w_t_mag    = (sgn && T[WIDTH-1]) ? -T : T;
  assign w_acc_next = r_acc + (r_mult[0] ? r_mcand : '0);
  assign w_prod     = r_neg ? -r_acc : r_acc;

`ifdef MPY_SEQ_EARLY_TERM_EN
  // Stop once no 1 bits remain above the bit being processed in this cycle.
  assign w_last = (r_cnt == CW'(1)) || ((r_mult >> 1) == '0);
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of the order of the blocks.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default comes first, so no path through the case infers a latch.
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture in IDLE and one shift-add step per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath registers are cleared on reset as well, so an aborted
    // operation leaves no stale magnitude or count behind.
    if (reset) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_s_mag};
            r_mult  <= w_t_mag;
            r_cnt   <= CW'(WIDTH);
            r_neg   <= sgn && (S[WIDTH-1] ^ T[WIDTH-1]);
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Results and flags load only on leaving DONE, and the done pulse comes with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_y_hi <= '0;
      r_y_lo <= '0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_n    <= 1'b0;
      r_z    <= 1'b1;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_y_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_y_lo <= w_prod[WIDTH-1:0];
        r_c    <= 1'b0;
        r_v    <= 1'b0;
        r_n    <= w_prod[2*WIDTH-1];
        r_z    <= (w_prod == '0);
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign Y_hi = r_y_hi;
  assign Y_lo = r_y_lo;
  assign C    = r_c;
  assign V    = r_v;
  assign N    = r_n;
  assign Z    = r_z;

endmodule

// File: tb/tb_mpy_seq.sv
// tb_mpy_seq: scoreboard bench for mpy_seq (WIDTH=32). The issuing code pushes
// the expected product and latency. A monitor pops one entry on each done pulse.
module tb_mpy_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sgn;
  logic [W-1:0] S;
  logic [W-1:0] T;
  logic         busy;
  logic         done;
  logic [W-1:0] Y_hi;
  logic [W-1:0] Y_lo;
  logic         C;
  logic         V;
  logic         N;
  logic         Z;

  mpy_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .S(S), .T(T),
    .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo),
    .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        q[$];
  int          errors    = 0;
  int          checks    = 0;
  int          cyc       = 0;
  int          n_done    = 0;
  int          n_issued  = 0;
  int          n_aborted = 0;
  logic [63:0] last_prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_y_hi"}, 64'(Y_hi), 64'd0);
    check({tag, "_y_lo"}, 64'(Y_lo), 64'd0);
    check({tag, "_c"},    64'(C),    64'd0);
    check({tag, "_v"},    64'(V),    64'd0);
    check({tag, "_n"},    64'(N),    64'd0);
    check({tag, "_z"},    64'(Z),    64'd1);
  endtask

  // Reference model: the exact product, computed with native 64-bit arithmetic.
  function automatic logic [63:0] ref_prod(input logic sg, input logic [W-1:0] s, input logic [W-1:0] t);
    longint ps;
    if (sg) begin
      ps = longint'($signed(s)) * longint'($signed(t));
      return 64'(ps);
    end
    return 64'(s) * 64'(t);
  endfunction

  // Cycles from the start edge until done is seen.
  function automatic int ref_latency(input logic sg, input logic [W-1:0] t);
`ifdef MPY_SEQ_EARLY_TERM_EN
    logic [W-1:0] tm;
    int           k;
    tm = (sg && t[W-1]) ? (~t + 32'd1) : t;
    k  = 0;
    for (int i = 0; i < W; i++) if (tm[i]) k = i;
    return k + 2;
`else
    return (sg || !sg) ? W + 1 : W + 1;
`endif
  endfunction

  // Monitor: each done pulse pops one expectation and compares it.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with no operation pending, expected done=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("y_hi",    64'(Y_hi), 64'(e.prod[63:32]));
        check("y_lo",    64'(Y_lo), 64'(e.prod[31:0]));
        check("flag_c",  64'(C),    64'd0);
        check("flag_v",  64'(V),    64'd0);
        check("flag_n",  64'(N),    64'(e.prod[63]));
        check("flag_z",  64'(Z),    64'(e.prod == 64'd0));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        last_prod = e.prod;
      end
    end
  end

  // Waits for IDLE, pulses start for one cycle, then scrambles the operand inputs.
  task automatic issue(input logic sg, input logic [W-1:0] s, input logic [W-1:0] t);
    exp_t e;
    int   k;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected busy=0", k);
    end
    e.prod      = ref_prod(sg, s, t);
    e.lat       = ref_latency(sg, t);
    e.start_cyc = cyc + 1;
    q.push_back(e);
    n_issued++;
    sgn   = sg;
    S     = s;
    T     = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    S     = $urandom;
    T     = $urandom;
    sgn   = 1'($urandom);
  endtask

  // Waits until every pending expectation has been consumed.
  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results still pending, expected 0", q.size());
      n_aborted += q.size();
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] corners [5];

  initial begin
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    reset = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    S     = '0;
    T     = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("idle_hold");

    // Directed cases.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
    issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007); drain();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000); drain();
    issue(1'b0, 32'h1234_5678, 32'h0000_0000); drain();

    // A start pulsed while busy is ignored: one done pulse, first result kept.
    issue(1'b0, 32'h0000_1000, 32'h0000_0003);
    repeat (5) @(negedge clk);
    start = 1'b1;
    S     = 32'h0000_0099;
    T     = 32'h0000_0055;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("hold_y_hi", 64'(Y_hi), 64'(last_prod[63:32]));
    check("hold_y_lo", 64'(Y_lo), 64'(last_prod[31:0]));
    check("hold_busy", 64'(busy), 64'd0);

    // Back-to-back: the second start lands in the done cycle.
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0005);
    issue(1'b0, 32'h0000_0003, 32'h0000_0009);
    drain();

    // Reset during CALC aborts the operation without a done pulse.
    issue(1'b0, 32'h0000_ABCD, 32'hF000_1234);
    repeat (9) @(negedge clk);
    n_aborted += q.size();
    q.delete();
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_y_lo", 64'(Y_lo), 64'd0);
    issue(1'b0, 32'd6, 32'd7);
    drain();
    check("six_times_seven", 64'(Y_lo), 64'd42);

    // Randomized operations, mixed with corner operands.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] s;
      logic [W-1:0] t;
      s = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      t = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom >> $urandom_range(0, 31));
      issue(1'($urandom), s, t);
    end
    drain();

    check("done_count", 64'(n_done), 64'(n_issued - n_aborted));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by time limit, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
